// File: rtl/blink_sched.sv
// Round-robin LED blink scheduler: grants one requester at a time and plays
// its burst of N on/off blinks of P cycles each, followed by a P-cycle gap.
module blink_sched #(
    parameter int NREQ  = 4,
    parameter int CBITS = 8,
    parameter int NBITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*NBITS-1:0]   cnt_i,
    input  logic [CBITS-1:0]        period,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic                    led,
    output logic                    done,
    output logic [$clog2(NREQ)-1:0] done_id
);

    localparam int IW = $clog2(NREQ);
    localparam logic [IW-1:0] PTR_RST = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF,
        GAP
    } state_t;

    state_t           state, state_nxt;
    logic [CBITS-1:0] timer, timer_nxt;
    logic [CBITS-1:0] plen, plen_nxt;
    logic [NBITS-1:0] remaining, remaining_nxt;
    logic [IW-1:0]    ptr, ptr_nxt;
    logic [NREQ-1:0]  grant_nxt;
    logic             busy_nxt, led_nxt, done_nxt;
    logic [IW-1:0]    done_id_nxt;

    logic [IW:0]      pick;
    logic             pick_vld;
    logic [IW-1:0]    pick_idx;
    logic [NBITS-1:0] cnt_sel;
    logic             phase_end;

    // A programmed period of zero behaves as a one-cycle phase.
    function automatic logic [CBITS-1:0] eff_period(input logic [CBITS-1:0] p);
        return (p == '0) ? CBITS'(1) : p;
    endfunction

    // First set request strictly after the pointer, wrapping; MSB flags a hit.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   p);
        logic [IW:0]   res;
        logic [IW-1:0] cand;
        res  = '0;
        cand = p;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(p) + k) % NREQ);
            if (!res[IW] && r[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    assign pick      = rr_pick(req, ptr);
    assign pick_vld  = pick[IW];
    assign pick_idx  = pick[IW-1:0];
    assign cnt_sel   = cnt_i[int'(pick_idx)*NBITS +: NBITS];
    assign phase_end = (timer == plen - CBITS'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            plen      <= CBITS'(1);
            remaining <= '0;
            ptr       <= PTR_RST;
            grant     <= '0;
            busy      <= 1'b0;
            led       <= 1'b0;
            done      <= 1'b0;
            done_id   <= '0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            plen      <= plen_nxt;
            remaining <= remaining_nxt;
            ptr       <= ptr_nxt;
            grant     <= grant_nxt;
            busy      <= busy_nxt;
            led       <= led_nxt;
            done      <= done_nxt;
            done_id   <= done_id_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        plen_nxt      = plen;
        remaining_nxt = remaining;
        ptr_nxt       = ptr;
        grant_nxt     = grant;
        busy_nxt      = busy;
        led_nxt       = led;
        done_nxt      = 1'b0;
        done_id_nxt   = done_id;

        case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_nxt = onehot(pick_idx);
                    busy_nxt  = 1'b1;
                    ptr_nxt   = pick_idx;
                    plen_nxt  = eff_period(period);
                    timer_nxt = '0;
                    if (cnt_sel != '0) begin
                        state_nxt     = ON;
                        led_nxt       = 1'b1;
                        remaining_nxt = cnt_sel;
                    end else begin
                        state_nxt = GAP;
                        led_nxt   = 1'b0;
                    end
                end
            end

            ON: begin
                if (phase_end) begin
                    timer_nxt = '0;
                    led_nxt   = 1'b0;
                    state_nxt = OFF;
                end else begin
                    timer_nxt = timer + CBITS'(1);
                end
            end

            OFF: begin
                if (phase_end) begin
                    timer_nxt = '0;
                    if (remaining > NBITS'(1)) begin
                        remaining_nxt = remaining - NBITS'(1);
                        led_nxt       = 1'b1;
                        state_nxt     = ON;
                    end else begin
                        state_nxt = GAP;
                    end
                end else begin
                    timer_nxt = timer + CBITS'(1);
                end
            end

            GAP: begin
                // The done pulse lands on the first IDLE cycle, which may also arbitrate.
                if (phase_end) begin
                    timer_nxt   = '0;
                    state_nxt   = IDLE;
                    grant_nxt   = '0;
                    busy_nxt    = 1'b0;
                    done_nxt    = 1'b1;
                    done_id_nxt = ptr;
                end else begin
                    timer_nxt = timer + CBITS'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                busy_nxt  = 1'b0;
                led_nxt   = 1'b0;
            end
        endcase
    end

`ifndef SYNTHESIS
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_led_only_on:  assert property (@(posedge clk) disable iff (rst) led |-> (state == ON));
    a_busy_grant:   assert property (@(posedge clk) disable iff (rst) busy == (grant != '0));
`endif

endmodule

// File: tb/tb_blink_sched.sv
// Bench for blink_sched: directed scenarios and random traffic compared each
// cycle against a burst-timeline reference model.
module tb_blink_sched;

    localparam int NREQ  = 4;
    localparam int CBITS = 8;
    localparam int NBITS = 4;
    localparam int IW    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*NBITS-1:0] cnt;
    logic [CBITS-1:0]      period;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  led;
    logic                  done;
    logic [IW-1:0]         done_id;

    int errors = 0;
    int checks = 0;

    // Reference model: a burst is a timeline of length 2*N*P+P from grant.
    bit m_busy, m_done;
    int m_owner, m_ptr, m_n, m_p, m_k, m_len, m_done_id;

    blink_sched #(.NREQ(NREQ), .CBITS(CBITS), .NBITS(NBITS)) dut (
        .clk(clk), .rst(rst), .req(req), .cnt_i(cnt), .period(period),
        .grant(grant), .busy(busy), .led(led), .done(done), .done_id(done_id)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_owner = 0; m_ptr = NREQ - 1;
        m_n = 0; m_p = 1; m_k = 0; m_len = 0; m_done_id = 0;
    endtask

    task automatic model_step();
        bit found;
        m_done = 0;
        if (m_busy) begin
            m_k++;
            if (m_k == m_len) begin
                m_busy = 0; m_done = 1; m_done_id = m_owner;
            end
        end else begin
            found = 0;
            for (int k = 1; k <= NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (!found && req[j]) begin
                    found = 1; m_owner = j;
                end
            end
            if (found) begin
                m_busy = 1; m_ptr = m_owner; m_k = 0;
                m_n = int'(cnt[m_owner*NBITS +: NBITS]);
                m_p = (period == 0) ? 1 : int'(period);
                m_len = 2 * m_n * m_p + m_p;
            end
        end
    endtask

    function automatic logic [NREQ+2:0] exp_out();
        logic [NREQ-1:0] g;
        logic l;
        g = '0;
        l = 1'b0;
        if (m_busy) begin
            g[m_owner] = 1'b1;
            l = (m_k < 2 * m_n * m_p) && (((m_k / m_p) % 2) == 0);
        end
        return {g, m_busy, l, m_done};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        req = '0; cnt = '0; period = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; cnt = '0; period = '0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({grant, busy, led, done} !== '0) begin
            errors++; $display("FAIL reset_outputs got=%b exp=0", {grant, busy, led, done});
        end
        checks++;
        if (done_id !== '0) begin
            errors++; $display("FAIL reset_done_id got=%0d exp=0", done_id);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_burst();
        logic [13:0] led_seq;
        int done_cyc;
        do_reset();
        req = 4'b0001; cnt = '0; cnt[3:0] = 4'd3; period = 8'd2;
        led_seq = '0; done_cyc = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            req = '0;
            checks++;
            if ({grant, busy, led, done} !== exp_out()) begin
                errors++; $display("FAIL single cyc=%0d got=%b exp=%b", c, {grant, busy, led, done}, exp_out());
            end
            if (c <= 14) led_seq = {led_seq[12:0], led};
            if (done && done_cyc < 0) done_cyc = c;
            if (m_done) begin
                checks++;
                if (done_id !== IW'(m_done_id)) begin
                    errors++; $display("FAIL single_done_id got=%0d exp=%0d", done_id, m_done_id);
                end
            end
        end
        checks++;
        if (led_seq !== 14'b11001100110000) begin
            errors++; $display("FAIL single_led_seq got=%b exp=%b", led_seq, 14'b11001100110000);
        end
        checks++;
        if (done_cyc != 15) begin
            errors++; $display("FAIL single_done_cycle got=%0d exp=15", done_cyc);
        end
    endtask

    task automatic test_round_robin();
        int order[8];
        int ng;
        logic [NREQ-1:0] prev;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'b1111; cnt = {4'd1, 4'd1, 4'd1, 4'd1}; period = 8'd0 + 8'd1;
        ng = 0; prev = '0;
        for (int c = 1; c <= 21; c++) begin
            tick();
            checks++;
            if ({grant, busy, led, done} !== exp_out()) begin
                errors++; $display("FAIL rr cyc=%0d got=%b exp=%b", c, {grant, busy, led, done}, exp_out());
            end
            if (grant != '0 && prev == '0 && ng < 8) begin
                for (int b = 0; b < NREQ; b++) if (grant[b]) order[ng] = b;
                ng++;
            end
            prev = grant;
        end
        checks++;
        if (ng < 5) begin
            errors++; $display("FAIL rr_grant_count got=%0d exp>=5", ng);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (order[i] != exp_order[i]) begin
                    errors++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, order[i], exp_order[i]);
                end
            end
        end
        req = '0;
    endtask

    task automatic test_zero_count();
        int gcyc;
        int did;
        do_reset();
        req = 4'b0100; cnt = '0; period = 8'd0;
        gcyc = 0; did = -1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            req = '0;
            checks++;
            if ({grant, busy, led, done} !== exp_out()) begin
                errors++; $display("FAIL zero cyc=%0d got=%b exp=%b", c, {grant, busy, led, done}, exp_out());
            end
            if (grant == 4'b0100) gcyc++;
            if (done) did = int'(done_id);
        end
        checks++;
        if (gcyc != 1) begin
            errors++; $display("FAIL zero_grant_len got=%0d exp=1", gcyc);
        end
        checks++;
        if (did != 2) begin
            errors++; $display("FAIL zero_done_id got=%0d exp=2", did);
        end
    endtask

    task automatic test_mid_burst_change();
        int bcyc;
        int ndone;
        do_reset();
        req = 4'b0010; cnt = '0; cnt[7:4] = 4'd2; period = 8'd3;
        bcyc = 0; ndone = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c == 2) begin
                req = '0; period = 8'd7; cnt[7:4] = 4'd9;
            end
            checks++;
            if ({grant, busy, led, done} !== exp_out()) begin
                errors++; $display("FAIL midchg cyc=%0d got=%b exp=%b", c, {grant, busy, led, done}, exp_out());
            end
            if (busy) bcyc++;
            if (done) ndone++;
        end
        checks++;
        if (bcyc != 15 || ndone != 1) begin
            errors++; $display("FAIL midchg_len busy=%0d done=%0d exp busy=15 done=1", bcyc, ndone);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req = 4'b0010; cnt = '0; cnt[7:4] = 4'd3; period = 8'd2;
        for (int c = 1; c <= 10 && !(m_busy && m_k == 4); c++) begin
            tick();
            req = '0;
            checks++;
            if ({grant, busy, led, done} !== exp_out()) begin
                errors++; $display("FAIL rstmid cyc=%0d got=%b exp=%b", c, {grant, busy, led, done}, exp_out());
            end
        end
        checks++;
        if (led !== 1'b1 || grant !== 4'b0010) begin
            errors++; $display("FAIL rstmid_on led=%b grant=%b exp led=1 grant=0010", led, grant);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({grant, busy, led, done} !== '0) begin
            errors++; $display("FAIL rstmid_async got=%b exp=0", {grant, busy, led, done});
        end
        req = 4'b1001;
        #2 rst = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            errors++; $display("FAIL rstmid_first_grant got=%b exp=0001", grant);
        end
        req = '0;
        for (int c = 1; c <= 6; c++) tick();
        model_reset();
        do_reset();
    endtask

    task automatic test_max_period();
        int on_cyc;
        int b_cyc;
        int ndone;
        do_reset();
        req = 4'b1000; cnt = '0; cnt[15:12] = 4'd1; period = 8'd255;
        on_cyc = 0; b_cyc = 0; ndone = 0;
        for (int c = 1; c <= 770; c++) begin
            tick();
            req = '0;
            checks++;
            if ({grant, busy, led, done} !== exp_out()) begin
                errors++; $display("FAIL maxp cyc=%0d got=%b exp=%b", c, {grant, busy, led, done}, exp_out());
            end
            if (led) on_cyc++;
            if (busy) b_cyc++;
            if (done) ndone++;
        end
        checks++;
        if (on_cyc != 255 || b_cyc != 765 || ndone != 1) begin
            errors++; $display("FAIL maxp_len on=%0d busy=%0d done=%0d exp 255 765 1", on_cyc, b_cyc, ndone);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 1; c <= 2500; c++) begin
            req    = ($urandom_range(0, 3) == 0) ? 4'b0000 : NREQ'($urandom);
            cnt    = '0;
            for (int i = 0; i < NREQ; i++) cnt[i*NBITS +: NBITS] = NBITS'($urandom_range(0, 3));
            period = CBITS'($urandom_range(0, 3));
            tick();
            checks++;
            if ({grant, busy, led, done} !== exp_out()) begin
                errors++; $display("FAIL random cyc=%0d got=%b exp=%b", c, {grant, busy, led, done}, exp_out());
            end
            if (m_done) begin
                checks++;
                if (done_id !== IW'(m_done_id)) begin
                    errors++; $display("FAIL random_done_id cyc=%0d got=%0d exp=%0d", c, done_id, m_done_id);
                end
            end
        end
        req = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_burst();
        test_round_robin();
        test_zero_count();
        test_mid_burst_change();
        test_reset_mid_burst();
        test_max_period();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
